// File: rtl/serial_adder_ctrl_if.sv
// Host/cell bundle for the bit-serial adder control stage.
// master = the side that issues additions and hosts the full-adder cell,
// slave  = the control stage itself.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 5
);
    // host request
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
    // full adder cell, one bit pair per cycle
    logic             fa_a;
    logic             fa_b;
    logic             fa_cin;
    logic             fa_s;
    logic             fa_cout;
    // host response
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;

    modport master (
        output start, a_in, b_in, c_in, fa_s, fa_cout,
        input  fa_a, fa_b, fa_cin, busy, done, sum, c_out
    );

    modport slave (
        input  start, a_in, b_in, c_in, fa_s, fa_cout,
        output fa_a, fa_b, fa_cin, busy, done, sum, c_out
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder control stage: feeds an external 1-bit full adder cell one
// operand bit pair per cycle (LSB first), carries between cycles, and
// assembles a WIDTH-bit sum plus carry-out that is published in one step.
module serial_adder_ctrl #(
    parameter int WIDTH = 5
) (
    input logic               clk,
    input logic               rst,
    serial_adder_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] r_sh_q, r_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cy_q, cy_d;
    logic             c_out_q, c_out_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // State register; reset wins over any start in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_sh_q  <= '0;
            sum_q   <= '0;
            cy_q    <= 1'b0;
            c_out_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            r_sh_q  <= r_sh_d;
            sum_q   <= sum_d;
            cy_q    <= cy_d;
            c_out_q <= c_out_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: operand load, per-bit shift, and result publish.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        r_sh_d  = r_sh_q;
        sum_d   = sum_q;
        cy_d    = cy_q;
        c_out_d = c_out_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                // DONE accepts a new start too, so additions can run back-to-back
                if (bus.start) begin
                    a_sh_d  = bus.a_in;
                    b_sh_d  = bus.b_in;
                    cy_d    = bus.c_in;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                // start is deliberately ignored here; operands are already latched
                r_sh_d = {bus.fa_s, r_sh_q[WIDTH-1:1]};
                cy_d   = bus.fa_cout;
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // sum only ever changes here, so partial results never leak out
                    sum_d   = {bus.fa_s, r_sh_q[WIDTH-1:1]};
                    c_out_d = bus.fa_cout;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Cell drive and status: cell inputs are quiet outside SHIFT.
    always_comb begin
        bus.fa_a   = 1'b0;
        bus.fa_b   = 1'b0;
        bus.fa_cin = 1'b0;
        if (state_q == SHIFT) begin
            bus.fa_a   = a_sh_q[0];
            bus.fa_b   = b_sh_q[0];
            bus.fa_cin = cy_q;
        end
    end

    assign bus.busy  = (state_q == SHIFT);
    assign bus.done  = (state_q == DONE);
    assign bus.sum   = sum_q;
    assign bus.c_out = c_out_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed scenarios plus random
// additions, checked against plain integer arithmetic.
module tb_serial_adder_ctrl;
    localparam int W = 5;
    localparam int MASK = (1 << W) - 1;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;
    int   exp_sum;   // last published sum
    int   exp_co;

    serial_adder_ctrl_if #(.WIDTH(W)) bus ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // behavioural full adder cell
    assign bus.fa_s    = bus.fa_a ^ bus.fa_b ^ bus.fa_cin;
    assign bus.fa_cout = (bus.fa_a & bus.fa_b) | (bus.fa_cin & (bus.fa_a ^ bus.fa_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " busy"},  32'(bus.busy), 0);
        check({tag, " done"},  32'(bus.done), 0);
        check({tag, " sum"},   32'(bus.sum), 32'(exp_sum));
        check({tag, " c_out"}, 32'(bus.c_out), 32'(exp_co));
        check({tag, " fa"},    32'({bus.fa_a, bus.fa_b, bus.fa_cin}), 0);
    endtask

    // present a start with operands; takes effect at the next posedge
    task automatic go(input int a, input int b, input int c);
        bus.start = 1'b1;
        bus.a_in  = W'(a);
        bus.b_in  = W'(b);
        bus.c_in  = c[0];
    endtask

    // Runs one addition whose start is already presented. junk_cyc: SHIFT cycle
    // at which a stray start is pulsed (-1 none). rst_cyc: SHIFT cycle at which
    // reset is asserted (-1 none). chain: present next operands in DONE cycle.
    task automatic run(input int a, input int b, input int c, input string tag,
                       input int junk_cyc, input int rst_cyc,
                       input bit chain, input int na, input int nb, input int nc);
        int full, lo, cin_i;
        full = a + b + c;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a_in  = W'($urandom);
        bus.b_in  = W'($urandom);
        bus.c_in  = 1'($urandom);
        for (int i = 0; i < W; i++) begin
            lo    = (1 << i) - 1;
            cin_i = ((a & lo) + (b & lo) + c) >> i;
            check({tag, " busy"},   32'(bus.busy), 1);
            check({tag, " done"},   32'(bus.done), 0);
            check({tag, " held sum"}, 32'({bus.c_out, bus.sum}), 32'((exp_co << W) | exp_sum));
            check({tag, " fa_a"},   32'(bus.fa_a), 32'((a >> i) & 1));
            check({tag, " fa_b"},   32'(bus.fa_b), 32'((b >> i) & 1));
            check({tag, " fa_cin"}, 32'(bus.fa_cin), 32'(cin_i));
            if (i == junk_cyc) go($urandom, $urandom, $urandom);
            if (i == rst_cyc) begin
                bus.start = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                exp_sum = 0;
                exp_co  = 0;
                check_idle_outputs({tag, " post-rst"});
                for (int k = 0; k < W + 2; k++) begin
                    @(negedge clk);
                    check({tag, " no done"}, 32'(bus.done), 0);
                end
                return;
            end
            @(negedge clk);
            bus.start = 1'b0;
        end
        exp_sum = full & MASK;
        exp_co  = (full >> W) & 1;
        check({tag, " done"},  32'(bus.done), 1);
        check({tag, " busy"},  32'(bus.busy), 0);
        check({tag, " sum"},   32'(bus.sum), 32'(exp_sum));
        check({tag, " c_out"}, 32'(bus.c_out), 32'(exp_co));
        check({tag, " fa"},    32'({bus.fa_a, bus.fa_b, bus.fa_cin}), 0);
        if (chain) begin
            go(na, nb, nc);
            return;
        end
        @(negedge clk);
        check_idle_outputs({tag, " after"});
    endtask

    initial begin
        bit pend;
        int a, b, c, na, nb, nc, junk;
        n_chk   = 0;
        n_fail  = 0;
        exp_sum = 0;
        exp_co  = 0;
        rst       = 1'b1;
        bus.start = 1'b1;   // start under reset must be lost
        bus.a_in  = 5'd3;
        bus.b_in  = 5'd4;
        bus.c_in  = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check_idle_outputs("idle");

        go(13, 9, 0);
        run(13, 9, 0, "t1", -1, -1, 0, 0, 0, 0);
        go(31, 31, 1);
        run(31, 31, 1, "t2", -1, -1, 0, 0, 0, 0);
        go(0, 0, 0);
        run(0, 0, 0, "t3", -1, -1, 0, 0, 0, 0);
        go(17, 3, 0);
        run(17, 3, 0, "t4", 2, -1, 0, 0, 0, 0);
        go(21, 10, 0);
        run(21, 10, 0, "t5", -1, 3, 0, 0, 0, 0);
        go(7, 8, 0);
        run(7, 8, 0, "t6a", -1, -1, 1, 30, 2, 0);
        run(30, 2, 0, "t6b", -1, -1, 0, 0, 0, 0);

        pend = 0;
        for (int n = 0; n < 40; n++) begin
            if (!pend) begin
                a = $urandom_range(MASK);
                b = $urandom_range(MASK);
                c = $urandom_range(1);
                go(a, b, c);
            end
            junk = ($urandom_range(3) == 0) ? $urandom_range(W - 1) : -1;
            pend = ($urandom_range(2) == 0) && (n != 39);
            na = $urandom_range(MASK);
            nb = $urandom_range(MASK);
            nc = $urandom_range(1);
            run(a, b, c, "rand", junk, -1, pend, na, nb, nc);
            a = na;
            b = nb;
            c = nc;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // absolute time guard so the run can never hang
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
